// File: rtl/motor_ramp_ctrl.sv
// Slew-limited speed/direction sequencer producing the pwm_wrapper command word.
// Reversals ramp to zero, hold a dead time, flip direction, then ramp back up.
module motor_ramp_ctrl #(
    parameter int TICK_DIV   = 100000,
    parameter int STEP       = 64,
    parameter int DEAD_TICKS = 10
) (
    input  logic        CLK100MHZ,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_data,
    input  logic        estop,
    output logic [15:0] pwm_cmd,
    output logic        busy,
    output logic        at_target
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_TICKS - 1);
    localparam logic [15:0]   STEP16     = 16'(STEP);
    localparam logic [14:0]   STEP15     = 15'(STEP);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_UP    = 3'd1;
    localparam logic [2:0] ST_DOWN  = 3'd2;
    localparam logic [2:0] ST_DEAD  = 3'd3;
    localparam logic [2:0] ST_ESTOP = 3'd4;

    logic [2:0]    state_r, state_n;
    logic [14:0]   duty_r, duty_n;
    logic          dir_r, dir_n;
    logic [14:0]   tgt_mag_r, tgt_mag_n;
    logic          tgt_dir_r, tgt_dir_n;
    logic [TW-1:0] tick_cnt_r;
    logic [DW-1:0] dead_cnt_r, dead_n;
    logic          tick_s, accept_s, rev_s;
    logic [14:0]   floor_s;

    // Sum is formed in 16 bits so a large step near full scale cannot wrap.
    function automatic logic [14:0] step_up(input logic [14:0] d, input logic [14:0] lim);
        logic [15:0] sum;
        sum = {1'b0, d} + STEP16;
        if (sum > {1'b0, lim}) begin
            step_up = lim;
        end else begin
            step_up = sum[14:0];
        end
    endfunction

    function automatic logic [14:0] step_down(input logic [14:0] d, input logic [14:0] flr);
        logic [14:0] diff;
        if ({1'b0, d} >= STEP16) begin
            diff = d - STEP15;
        end else begin
            diff = 15'd0;
        end
        if (diff < flr) begin
            step_down = flr;
        end else begin
            step_down = diff;
        end
    endfunction

    assign tick_s    = (tick_cnt_r == TICK_LAST);
    assign cmd_ready = (state_r != ST_ESTOP);
    assign accept_s  = cmd_valid && cmd_ready;
    assign rev_s     = (tgt_mag_r != 15'd0) && (tgt_dir_r != dir_r);
    assign floor_s   = rev_s ? 15'd0 : tgt_mag_r;
    assign pwm_cmd   = {dir_r, duty_r};
    assign busy      = (state_r != ST_IDLE);
    assign at_target = (state_r == ST_IDLE);

    // Free-running ramp tick divider, unaffected by estop.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // Next-state, duty, direction and target selection.
    always_comb begin
        state_n   = state_r;
        duty_n    = duty_r;
        dir_n     = dir_r;
        tgt_mag_n = tgt_mag_r;
        tgt_dir_n = tgt_dir_r;
        dead_n    = dead_cnt_r;
        if (estop) begin
            state_n   = ST_ESTOP;
            duty_n    = 15'd0;
            tgt_mag_n = 15'd0;
        end else begin
            if (accept_s) begin
                tgt_mag_n = cmd_data[14:0];
                tgt_dir_n = cmd_data[15];
            end else begin
                tgt_mag_n = tgt_mag_r;
                tgt_dir_n = tgt_dir_r;
            end
            // Decisions use the target registered before this edge.
            case (state_r)
                ST_IDLE: begin
                    if (rev_s) begin
                        if (duty_r != 15'd0) begin
                            state_n = ST_DOWN;
                        end else begin
                            state_n = ST_DEAD;
                            dead_n  = '0;
                        end
                    end else if (tgt_mag_r > duty_r) begin
                        state_n = ST_UP;
                    end else if (tgt_mag_r < duty_r) begin
                        state_n = ST_DOWN;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_UP: begin
                    if (rev_s || (tgt_mag_r < duty_r)) begin
                        state_n = ST_DOWN;
                    end else begin
                        if (tick_s) begin
                            duty_n = step_up(duty_r, tgt_mag_r);
                        end else begin
                            duty_n = duty_r;
                        end
                        if (duty_n == tgt_mag_r) begin
                            state_n = ST_IDLE;
                        end else begin
                            state_n = ST_UP;
                        end
                    end
                end
                ST_DOWN: begin
                    if (!rev_s && (tgt_mag_r > duty_r)) begin
                        state_n = ST_UP;
                    end else begin
                        if (tick_s) begin
                            duty_n = step_down(duty_r, floor_s);
                        end else begin
                            duty_n = duty_r;
                        end
                        if (duty_n == floor_s) begin
                            if (rev_s) begin
                                state_n = ST_DEAD;
                                dead_n  = '0;
                            end else begin
                                state_n = ST_IDLE;
                            end
                        end else begin
                            state_n = ST_DOWN;
                        end
                    end
                end
                ST_DEAD: begin
                    duty_n = 15'd0;
                    if (tick_s) begin
                        if (dead_cnt_r == DEAD_LAST) begin
                            dead_n = '0;
                            if (rev_s) begin
                                dir_n   = tgt_dir_r;
                                state_n = ST_UP;
                            end else if (tgt_mag_r != 15'd0) begin
                                state_n = ST_UP;
                            end else begin
                                state_n = ST_IDLE;
                            end
                        end else begin
                            dead_n = dead_cnt_r + DW'(1);
                        end
                    end else begin
                        dead_n = dead_cnt_r;
                    end
                end
                ST_ESTOP: begin
                    state_n = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                    duty_n  = 15'd0;
                end
            endcase
        end
    end

    // Control and datapath registers.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            duty_r     <= 15'd0;
            dir_r      <= 1'b0;
            tgt_mag_r  <= 15'd0;
            tgt_dir_r  <= 1'b0;
            dead_cnt_r <= '0;
        end else begin
            state_r    <= state_n;
            duty_r     <= duty_n;
            dir_r      <= dir_n;
            tgt_mag_r  <= tgt_mag_n;
            tgt_dir_r  <= tgt_dir_n;
            dead_cnt_r <= dead_n;
        end
    end

endmodule

// File: doc/motor_ramp_ctrl.md
# motor_ramp_ctrl

Sequencer that sits in front of `pwm_wrapper` and produces its 16-bit `data_in` command word. It accepts target speed/direction commands over a valid/ready handshake and ramps the duty magnitude toward the target at a fixed slew rate. Every direction reversal is made safe: ramp to zero, hold a dead time, flip direction, then ramp up. An emergency-stop input overrides everything.

## Interface
- `TICK_DIV`, default 100000: clock cycles per ramp tick (1 ms at 100 MHz); minimum 2.
- `STEP`, default 64: maximum duty change per tick; range 1..32767.
- `DEAD_TICKS`, default 10: ticks held at zero duty before a direction flip; minimum 1.
- `CLK100MHZ` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command can be accepted; equals `state != ESTOP`.
- `cmd_data` in 16: `{dir, mag[14:0]}`.
- `estop` in 1: emergency stop, level-sensitive.
- `pwm_cmd` out 16: `{dir_q, duty_q[14:0]}`, registered; connects to `pwm_wrapper.data_in`.
- `busy` out 1: `state != IDLE`.
- `at_target` out 1: `state == IDLE`.

## Operation
- Registers: `duty_q[14:0]`, `dir_q`, `tgt_mag[14:0]`, `tgt_dir`, tick counter, dead counter, `state`.
- Tick counter free-runs 0..TICK_DIV-1. `tick` is high for one cycle when count == TICK_DIV-1.
- Accept occurs when `cmd_valid && cmd_ready`. The accept edge loads `tgt_mag` and `tgt_dir`. A later command overwrites the target at any time outside ESTOP.
- `rev` = (`tgt_mag != 0`) && (`tgt_dir != dir_q`). The dir bit is ignored when `mag == 0`.
- IDLE:
  - `rev`: go to RAMP_DOWN if duty>0, else DEAD.
  - else if `tgt_mag > duty`: go to RAMP_UP.
  - else if `tgt_mag < duty`: go to RAMP_DOWN.
- RAMP_UP:
  - On tick, `duty = min(duty+STEP, tgt_mag)`; compute the sum in 16 bits so it cannot wrap.
  - If `rev` or `tgt_mag < duty`: go to RAMP_DOWN.
  - If `duty == tgt_mag`: go to IDLE.
- RAMP_DOWN:
  - `floor` = `rev ? 0 : tgt_mag`.
  - On tick, `duty = max(duty-STEP, floor)`, saturating.
  - If `duty == floor`: go to DEAD if `rev`, else IDLE.
  - If `!rev && tgt_mag > duty`: go to RAMP_UP.
- DEAD:
  - Duty is held at 0. The dead counter clears on entry and increments on tick.
  - On reaching DEAD_TICKS the dead time always completes. Then:
    - if `rev`, `dir_q <= tgt_dir` and go to RAMP_UP;
    - else go to RAMP_UP if `tgt_mag>0`, otherwise IDLE.
- ESTOP:
  - Entered from any state when `estop` is high.
  - Entry edge forces `duty_q = 0` and `tgt_mag = 0`; `dir_q` is retained.
  - Commands are not accepted (`cmd_ready = 0`).
  - Leaves to IDLE on the first edge with `estop` low.
- `estop` has priority over the accept and over every transition in the same cycle.

## Timing
- Reset values (edge with `rst` high):
  - `state` = IDLE; `duty_q`, `dir_q`, `tgt_mag`, `tgt_dir`, tick counter and dead counter all 0.
  - Outputs: `pwm_cmd` = 16'h0000, `busy` = 0, `at_target` = 1, `cmd_ready` = 1.
- A command presented while `rst` is high is dropped. Reset mid-ramp returns to the reset values on the next edge.
- Accept at edge N: target visible at N; FSM leaves IDLE at edge N+1, so `busy` rises 1 cycle after the accept edge.
- Duty changes only on tick edges; `pwm_cmd` reflects the new duty the same edge.
- Zero-to-full ramp takes ceil(32767/STEP) ticks.
- Overshoot past the target is forbidden. The final step is clamped.
- `estop` asserted in cycle N: `pwm_cmd[14:0]` = 0 and `cmd_ready` = 0 after edge N. The tick counter keeps running.
- Direction flip occurs on the DEAD→RAMP_UP edge with duty 0. `dir_q` never changes while `duty_q != 0`.

## Test plan
All scenarios use `TICK_DIV`=4, `STEP`=100, `DEAD_TICKS`=2.
- **Reset:** hold `rst` 3 cycles with `cmd_valid`=1 → `pwm_cmd` 0x0000, `busy`=0, `at_target`=1, `cmd_ready`=1; the command is not taken.
- **Ramp up:** from reset, send `{0,250}` → duty 100, 200, 250 on successive ticks (4 cycles apart); `at_target`=1 once duty reaches 250; `pwm_cmd` = 0x00FA.
- **Reversal:** at 250 forward, send `{1,150}` → duty 150, 50, 0; 2 ticks at 0; dir flips with duty 0; duty 100, 150; final `pwm_cmd` = 0x8096.
- **Retarget mid-ramp:** ramping to 500 and duty at 200, send `{0,120}` → next tick duty 120 (clamped, not 100), then IDLE.
- **Estop:** at duty 200, pulse `estop` 3 cycles with a command presented → `pwm_cmd` 0x0000 the next edge, `cmd_ready` 0, command ignored; after release, IDLE with `at_target`=1, duty 0.
- **Zero-magnitude reverse:** at duty 0 dir 0, send `{1,0}` → no DEAD entry and no dir flip; `pwm_cmd` stays 0x0000.
